// File: rtl/mole_hit_scorer.sv
// mole_hit_scorer: synchronizes and debounces four player buttons and judges each press
// against the mole lamp currently lit. It keeps a saturating two-digit BCD score and a miss
// count, and locks into a game-over state when the miss count reaches LIVES.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   in1..in4        : raw buttons, active-high
//   o1..o4          : mole lamps from the randomiser, active-high
//   score           : BCD score ([7:4] tens, [3:0] units)
//   misses          : binary miss count
//   hit, miss       : one-cycle judgement pulses
//   game_over       : level, high in the OVER state
module mole_hit_scorer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LIVES           = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       in4,
  input  logic       o1,
  input  logic       o2,
  input  logic       o3,
  input  logic       o4,
  output logic [7:0] score,
  output logic [2:0] misses,
  output logic       hit,
  output logic       miss,
  output logic       game_over
);

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] DB_PRE = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] LIVES3 = 3'(LIVES);

  typedef enum logic [1:0] {IDLE, ARMED, SCORED, OVER} state_t;

  // Two-flop synchronizers for buttons and lamps
  logic [3:0] btn_meta, btn_sync, lamp_meta, lamp_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      lamp_meta <= '0;
      lamp_sync <= '0;
    end else begin
      btn_meta  <= {in4, in3, in2, in1};
      btn_sync  <= btn_meta;
      lamp_meta <= {o4, o3, o2, o1};
      lamp_sync <= lamp_meta;
    end
  end

  // Debounce: the counter parks at DEBOUNCE_CYCLES while the button stays high, so the
  // press pulse fires exactly once per high stretch; only a low cycle clears it.
  logic [3:0][3:0] cnt;
  logic [3:0]      press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      press <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!btn_sync[b]) begin
          cnt[b]   <= '0;
          press[b] <= 1'b0;
        end else begin
          if (cnt[b] != DB_MAX) cnt[b] <= cnt[b] + 4'd1;
          press[b] <= (cnt[b] == DB_PRE);
        end
      end
    end
  end

  // Mole index decode: only a single lit lamp is a valid mole
  logic       mole_vld;
  logic [1:0] mole_idx;

  always_comb begin
    mole_vld = 1'b1;
    mole_idx = 2'd0;
    case (lamp_sync)
      4'b0001: mole_idx = 2'd0;
      4'b0010: mole_idx = 2'd1;
      4'b0100: mole_idx = 2'd2;
      4'b1000: mole_idx = 2'd3;
      default: mole_vld = 1'b0;
    endcase
  end

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)         return v;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Game FSM
  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] score_n;
  logic [2:0] misses_n;
  logic       hit_n, miss_n, take_miss;
  logic [3:0] sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 2'd0;
      score  <= 8'h00;
      misses <= 3'd0;
      hit    <= 1'b0;
      miss   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      score  <= score_n;
      misses <= misses_n;
      hit    <= hit_n;
      miss   <= miss_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    score_n   = score;
    misses_n  = misses;
    hit_n     = 1'b0;
    miss_n    = 1'b0;
    take_miss = 1'b0;
    sel       = 4'b0001 << idx;
    case (state)
      IDLE: begin
        if (mole_vld) begin
          idx_n   = mole_idx;
          state_n = ARMED;
        end
      end
      ARMED: begin
        // Presses are judged against the index latched before any same-cycle lamp change;
        // a hit masks both wrong-button and escape misses.
        if ((press & sel) != 4'b0000) begin
          hit_n   = 1'b1;
          score_n = bcd_inc(score);
          state_n = SCORED;
        end else begin
          if (press != 4'b0000) take_miss = 1'b1;
          if (!mole_vld) begin
            take_miss = 1'b1;
            state_n   = IDLE;
          end else if (mole_idx != idx) begin
            take_miss = 1'b1;
            idx_n     = mole_idx;
          end
        end
      end
      SCORED: begin
        if (!mole_vld) begin
          state_n = IDLE;
        end else if (mole_idx != idx) begin
          idx_n   = mole_idx;
          state_n = ARMED;
        end
      end
      default: ;  // OVER: frozen until reset
    endcase
    if (take_miss) begin
      miss_n   = 1'b1;
      misses_n = misses + 3'd1;
      if (misses + 3'd1 == LIVES3) state_n = OVER;
    end
  end

  assign game_over = (state == OVER);

endmodule

// File: tb/tb_mole_hit_scorer.sv
module tb_mole_hit_scorer;

  localparam int D     = 4;
  localparam int LIVES = 3;

  logic       clk, rst_n;
  logic [3:0] btn, lamp;
  logic [7:0] score;
  logic [2:0] misses;
  logic       hit, miss, game_over;

  mole_hit_scorer #(.DEBOUNCE_CYCLES(D), .LIVES(LIVES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in1(btn[0]), .in2(btn[1]), .in3(btn[2]), .in4(btn[3]),
    .o1(lamp[0]), .o2(lamp[1]), .o3(lamp[2]), .o4(lamp[3]),
    .score(score), .misses(misses), .hit(hit), .miss(miss), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int hit_cnt = 0, miss_cnt = 0;
  bit dir_on = 0, rand_on = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  // Reference model: a press is a run of exactly D consecutive high samples of the
  // two-cycle-delayed button; the game is tracked as plain integers.
  int         m_score, m_misses, m_mode, m_idx, m_nidx;  // mode: 0 idle, 1 armed, 2 scored, 3 over
  int         run [4];
  logic [3:0] m_press, pf, bs, ls;
  logic [3:0] bq[$], lq[$];
  bit         m_hit, m_miss, m_vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_score = 0; m_misses = 0; m_mode = 0; m_idx = 0;
      m_press = '0; m_hit = 0; m_miss = 0;
      for (int b = 0; b < 4; b++) run[b] = 0;
      bq.delete(); lq.delete();
    end else begin
      pf = m_press;
      bq.push_back(btn);
      lq.push_back(lamp);
      bs = '0; ls = '0;
      if (bq.size() > 2) bs = bq.pop_front();
      if (lq.size() > 2) ls = lq.pop_front();
      for (int b = 0; b < 4; b++) begin
        if (bs[b]) run[b] = (run[b] < 1000) ? run[b] + 1 : run[b];
        else       run[b] = 0;
        m_press[b] = (run[b] == D);
      end
      m_vld  = ($countones(ls) == 1);
      m_nidx = 0;
      for (int b = 0; b < 4; b++) if (ls[b]) m_nidx = b;
      m_hit = 0; m_miss = 0;
      case (m_mode)
        0: if (m_vld) begin m_idx = m_nidx; m_mode = 1; end
        1: begin
          if (pf[m_idx]) begin
            m_hit = 1; m_score = (m_score < 99) ? m_score + 1 : 99; m_mode = 2;
          end else begin
            if (pf != 0) m_miss = 1;
            if (!m_vld) begin m_miss = 1; m_mode = 0; end
            else if (m_nidx != m_idx) begin m_miss = 1; m_idx = m_nidx; end
          end
        end
        2: begin
          if (!m_vld) m_mode = 0;
          else if (m_nidx != m_idx) begin m_idx = m_nidx; m_mode = 1; end
        end
        default: ;
      endcase
      if (m_miss) begin
        m_misses++;
        if (m_misses == LIVES) m_mode = 3;
      end
    end
  end

  always @(negedge clk) begin
    if (hit)  hit_cnt++;
    if (miss) miss_cnt++;
    if (dir_on && miss) chk("go_with_miss", game_over, int'(misses == 3'(LIVES)));
    if (rand_on) begin
      chk("rnd_score", score, bcd(m_score));
      chk("rnd_misses", misses, m_misses);
      chk("rnd_hit", hit, m_hit);
      chk("rnd_miss", miss, m_miss);
      chk("rnd_go", game_over, int'(m_mode == 3));
      chk("rnd_excl", int'(hit && miss), 0);
    end
  end

  typedef struct {
    logic [3:0] lamp;
    logic [3:0] btn;
    int         hold;
    int         hits;
    int         miss_p;
    int         score;
    int         misses;
    int         go;
  } vec_t;

  vec_t tbl [12];

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    btn = '0;
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  int first_c;

  initial begin
    // lamp,   btn,    hold, hits, miss, score, misses, go
    tbl[0]  = '{4'b0010, 4'b0010, 10, 1, 0, 8'h01, 0, 0};  // hit; long hold no repeat
    tbl[1]  = '{4'b0010, 4'b0010,  6, 0, 0, 8'h01, 0, 0};  // SCORED ignores presses
    tbl[2]  = '{4'b0100, 4'b1001,  6, 0, 1, 8'h01, 1, 0};  // two wrong buttons, one miss
    tbl[3]  = '{4'b0100, 4'b0100,  6, 1, 0, 8'h02, 1, 0};
    tbl[4]  = '{4'b0000, 4'b0001,  6, 0, 0, 8'h02, 1, 0};  // no mole: idle ignores
    tbl[5]  = '{4'b0011, 4'b0001,  6, 0, 0, 8'h02, 1, 0};  // two lamps = no mole
    tbl[6]  = '{4'b0001, 4'b0000,  0, 0, 0, 8'h02, 1, 0};
    tbl[7]  = '{4'b1000, 4'b0000,  0, 0, 1, 8'h02, 2, 0};  // escape miss
    tbl[8]  = '{4'b1000, 4'b1000,  6, 1, 0, 8'h03, 2, 0};
    tbl[9]  = '{4'b0010, 4'b0010,  2, 0, 0, 8'h03, 2, 0};  // 2-cycle glitch
    tbl[10] = '{4'b0010, 4'b0100,  6, 0, 1, 8'h03, 3, 1};  // last life
    tbl[11] = '{4'b0001, 4'b0001,  6, 0, 0, 8'h03, 3, 1};  // OVER ignores all

    rst_n = 1'b0; btn = '0; lamp = '0;
    cycles(3); #2;
    chk("rst_score", score, 0);
    chk("rst_misses", misses, 0);
    chk("rst_hit", hit, 0);
    chk("rst_miss", miss, 0);
    chk("rst_go", game_over, 0);
    rst_n = 1'b1;
    cycles(2);

    dir_on = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hit_cnt = 0; miss_cnt = 0;
      lamp = tbl[i].lamp;
      cycles(4);
      if (tbl[i].hold > 0) begin
        btn = tbl[i].btn;
        cycles(tbl[i].hold);
        btn = '0;
      end
      cycles(10);
      chk($sformatf("v%0d_hits", i), hit_cnt, tbl[i].hits);
      chk($sformatf("v%0d_miss", i), miss_cnt, tbl[i].miss_p);
      chk($sformatf("v%0d_score", i), score, tbl[i].score);
      chk($sformatf("v%0d_misses", i), misses, tbl[i].misses);
      chk($sformatf("v%0d_go", i), game_over, tbl[i].go);
    end
    dir_on = 0;

    // Asynchronous reset from OVER takes effect immediately
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_score", score, 0);
    chk("arst_misses", misses, 0);
    chk("arst_go", game_over, 0);
    chk("arst_hit", hit, 0);
    chk("arst_miss", miss, 0);
    cycles(2); #2;
    rst_n = 1'b1;

    // Reset mid-debounce: the partial press is discarded
    lamp = 4'b0001;
    cycles(4);
    btn = 4'b0001;
    cycles(3); #2;
    rst_n = 1'b0;
    btn = '0;
    cycles(2); #2;
    rst_n = 1'b1;
    hit_cnt = 0; miss_cnt = 0;
    cycles(20);
    chk("mid_rst_hits", hit_cnt, 0);
    chk("mid_rst_miss", miss_cnt, 0);
    chk("mid_rst_score", score, 0);

    // Press latency: hit visible just after edge E+D+2, E being the first sampling edge
    @(negedge clk);
    btn = 4'b0001;
    first_c = 0;
    for (int c = 1; c <= D + 6; c++) begin
      @(posedge clk); #1;
      if (hit && first_c == 0) first_c = c;
    end
    chk("latency", first_c, D + 3);
    chk("latency_score", score, 8'h01);
    @(negedge clk);
    btn = '0;
    cycles(4);

    // Score run to saturation
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      hit_cnt = 0;
      lamp = (i % 2) ? 4'b0001 : 4'b0010;
      cycles(4);
      btn = lamp;
      cycles(5);
      btn = '0;
      cycles(8);
      if (i == 9 || i == 10 || i == 99 || i == 100) begin
        chk($sformatf("sat%0d_score", i), score, bcd((i < 99) ? i : 99));
        chk($sformatf("sat%0d_hit", i), hit_cnt, 1);
      end else if (score != 8'(bcd(i))) begin
        chk($sformatf("run%0d_score", i), score, bcd(i));
      end
    end
    chk("sat_misses", misses, 0);

    // Randomized play against the reference model
    do_reset();
    lamp = '0;
    rand_on = 1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk); #2;
      if (game_over || (n % 600) == 599) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) lamp = 4'b0001 << $urandom_range(0, 3);
        else                           lamp = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    rand_on = 0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
